// File: rtl/riscv_pkg.sv
// Shared constants and types for the retire-side observer blocks.
// Opcode constants, default halt-sequence words and the halt FSM state type.
package riscv_pkg;

   localparam logic [6:0]  OP_BRANCH      = 7'b1100011;
   localparam logic [6:0]  OP_STORE       = 7'b0100011;

   localparam logic [31:0] HALT_INST0_DEF = 32'h00C0_0093;  // addi x1,x0,12
   localparam logic [31:0] HALT_INST1_DEF = 32'h0000_8067;  // jalr x0,0(x1)

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      HALTED = 2'd2
   } halt_state_e;

endpackage

// File: rtl/riscv_halt_detector.sv
// Watches the retire stream for the two-word halt sequence; HALT is sticky
// until reset. Only valid retires advance the FSM, so bubbles never disarm it.
module riscv_halt_detector
   import riscv_pkg::*;
#(
   parameter logic [31:0] HALT_INST0 = HALT_INST0_DEF,
   parameter logic [31:0] HALT_INST1 = HALT_INST1_DEF
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        RET_VALID,
   input  logic [31:0] RET_INST,
   output logic        HALT
);

   halt_state_e state, state_next;

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (!RSTn) state <= IDLE;
      else       state <= state_next;
   end

   // NOTE: state_next is assigned a default first so no path through the case infers a latch.
   always_comb begin
      state_next = state;
      if (RET_VALID) begin
         unique case (state)
            IDLE:    if (RET_INST == HALT_INST0) state_next = ARMED;
            ARMED: begin
               if      (RET_INST == HALT_INST1) state_next = HALTED;
               else if (RET_INST == HALT_INST0) state_next = ARMED;
               else                             state_next = IDLE;
            end
            HALTED:  state_next = HALTED;
            default: state_next = IDLE;
         endcase
      end
   end

   assign HALT = (state == HALTED);

endmodule

// File: rtl/riscv_retire_monitor.sv
// Commit-side observer: retired-instruction counter, observable output port,
// halt detection and a watchdog flag. Never feeds back into the datapath.
module riscv_retire_monitor
   import riscv_pkg::*;
#(
   parameter logic [31:0] HALT_INST0 = HALT_INST0_DEF,
   parameter logic [31:0] HALT_INST1 = HALT_INST1_DEF,
   parameter logic [31:0] MAX_INST   = 32'hFFFF_FFFF
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        RET_VALID,
   input  logic [31:0] RET_INST,
   input  logic        RET_RD_WE,
   input  logic [31:0] RET_RD_WD,
   input  logic        RET_BR_TAKEN,
   input  logic [31:0] RET_MEM_ADDR,
   output logic [31:0] NUM_INST,
   output logic [31:0] OUTPUT_PORT,
   output logic        HALT,
   output logic        TIMEOUT
);

   logic        retire;
   logic        count_en;
   logic [31:0] count_next;
   logic [31:0] out_next;

   riscv_halt_detector #(
      .HALT_INST0 (HALT_INST0),
      .HALT_INST1 (HALT_INST1)
   ) u_halt_detector (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .RET_VALID (RET_VALID),
      .RET_INST  (RET_INST),
      .HALT      (HALT)
   );

   // Once halted the architectural view is frozen; the halting jalr itself still counts.
   assign retire     = RET_VALID && !HALT;
   assign count_en   = retire && (NUM_INST != 32'hFFFF_FFFF);
   assign count_next = NUM_INST + 32'd1;

   always_comb begin
      out_next = OUTPUT_PORT;
      if (retire) begin
         if      (RET_INST[6:0] == OP_BRANCH) out_next = {31'b0, RET_BR_TAKEN};
         else if (RET_INST[6:0] == OP_STORE)  out_next = RET_MEM_ADDR;
         else if (RET_RD_WE)                  out_next = RET_RD_WD;
      end
   end

   // Counter and output port share one edge so the bench always sees a matched pair.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         NUM_INST    <= 32'd0;
         OUTPUT_PORT <= 32'd0;
         TIMEOUT     <= 1'b0;
      end else begin
         OUTPUT_PORT <= out_next;
         if (count_en) begin
            NUM_INST <= count_next;
            if (count_next == MAX_INST) TIMEOUT <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_riscv_retire_monitor.sv
// Randomised + directed bench for riscv_retire_monitor with a queue scoreboard
// fed by a behavioural model of the retire rules.
module tb_riscv_retire_monitor;

   localparam logic [31:0] H0      = 32'h00C0_0093;
   localparam logic [31:0] H1      = 32'h0000_8067;
   localparam logic [31:0] MAX     = 32'd4;
   localparam logic [31:0] I_ADDI  = 32'h0050_0093;
   localparam logic [31:0] I_SLTI  = 32'h0000_2013;
   localparam logic [31:0] I_BEQ   = 32'h0000_0063;
   localparam logic [31:0] I_SW    = 32'h0000_2023;
   localparam logic [31:0] I_ADD   = 32'h0000_0033;

   typedef struct {
      logic [31:0] num;
      logic [31:0] out;
      logic        halt;
      logic        tmo;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RSTn = 1'b0;
   logic        RET_VALID = 1'b0;
   logic [31:0] RET_INST = '0;
   logic        RET_RD_WE = 1'b0;
   logic [31:0] RET_RD_WD = '0;
   logic        RET_BR_TAKEN = 1'b0;
   logic [31:0] RET_MEM_ADDR = '0;
   logic [31:0] NUM_INST, OUTPUT_PORT;
   logic        HALT, TIMEOUT;

   int   total = 0;
   int   bad = 0;
   exp_t sb[$];

   // reference model state
   longint      m_cnt;
   logic [31:0] m_out;
   bit          m_halt, m_tmo, m_have_prev;
   logic [31:0] m_prev;

   riscv_retire_monitor #(
      .HALT_INST0 (H0),
      .HALT_INST1 (H1),
      .MAX_INST   (MAX)
   ) dut (
      .CLK          (CLK),
      .RSTn         (RSTn),
      .RET_VALID    (RET_VALID),
      .RET_INST     (RET_INST),
      .RET_RD_WE    (RET_RD_WE),
      .RET_RD_WD    (RET_RD_WD),
      .RET_BR_TAKEN (RET_BR_TAKEN),
      .RET_MEM_ADDR (RET_MEM_ADDR),
      .NUM_INST     (NUM_INST),
      .OUTPUT_PORT  (OUTPUT_PORT),
      .HALT         (HALT),
      .TIMEOUT      (TIMEOUT)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // One cycle of stimulus: drive inputs, advance the model, queue what must appear after the edge.
   task automatic drive(input bit rstn, input bit valid, input logic [31:0] inst,
                        input bit we, input logic [31:0] wd, input bit br,
                        input logic [31:0] addr);
      exp_t e;
      RSTn = rstn; RET_VALID = valid; RET_INST = inst; RET_RD_WE = we;
      RET_RD_WD = wd; RET_BR_TAKEN = br; RET_MEM_ADDR = addr;
      if (!rstn) begin
         m_cnt = 0; m_out = '0; m_halt = 0; m_tmo = 0; m_have_prev = 0; m_prev = '0;
      end else if (valid && !m_halt) begin
         if (m_cnt < 64'hFFFF_FFFF) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == longint'(MAX)) m_tmo = 1;
         end
         if      (inst[6:0] == 7'b1100011) m_out = {31'b0, br};
         else if (inst[6:0] == 7'b0100011) m_out = addr;
         else if (we)                      m_out = wd;
         // halt completes when H1 retires directly after H0 (bubbles ignored)
         if (m_have_prev && m_prev == H0 && inst == H1) m_halt = 1;
         m_prev = inst;
         m_have_prev = 1;
      end
      e.num = m_cnt[31:0]; e.out = m_out; e.halt = m_halt; e.tmo = m_tmo;
      sb.push_back(e);
      @(negedge CLK);
   endtask

   task automatic ret(input logic [31:0] inst, input bit we, input logic [31:0] wd);
      drive(1, 1, inst, we, wd, 0, 32'h0);
   endtask

   task automatic bubble();
      drive(1, 0, $urandom, $urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom);
   endtask

   task automatic do_reset();
      drive(0, 1, I_ADDI, 1, 32'hDEAD_BEEF, 0, 32'h0);
      drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
   endtask

   // Monitor: outputs are presented every cycle, compared #1 after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("num_inst",    NUM_INST,          e.num);
            check("output_port", OUTPUT_PORT,       e.out);
            check("halt",        {31'b0, HALT},     {31'b0, e.halt});
            check("timeout",     {31'b0, TIMEOUT},  {31'b0, e.tmo});
         end
      end
   end

   initial begin
      logic [31:0] w;
      @(negedge CLK);
      do_reset();

      // basic counting and rd writeback
      ret(I_ADDI, 1, 32'd5);
      ret(I_SLTI, 1, 32'd0);
      ret(I_SLTI, 1, 32'd1);
      // branch, store, no-writeback hold; count crosses MAX here
      drive(1, 1, I_BEQ, 0, 32'h55, 1, 32'h0);
      drive(1, 1, I_SW, 0, 32'h66, 0, 32'h100);
      ret(I_ADD, 0, 32'h77);

      // halt sequence with bubbles, then frozen
      do_reset();
      ret(H0, 1, 32'd12);
      bubble();
      bubble();
      ret(H1, 0, 32'h0);
      ret(I_ADDI, 1, 32'd9);
      drive(1, 1, I_SW, 0, 32'h0, 0, 32'h200);
      // reset with a retire present, then lone H1 must not halt
      drive(0, 1, I_ADDI, 1, 32'd3, 0, 32'h0);
      ret(H1, 0, 32'h0);
      ret(I_ADDI, 1, 32'd4);

      // broken sequence
      do_reset();
      ret(H0, 1, 32'd12);
      ret(I_ADD, 1, 32'd8);
      ret(H1, 0, 32'h0);

      // repeated first word keeps the detector armed
      do_reset();
      ret(H0, 1, 32'd12);
      ret(H0, 1, 32'd12);
      ret(H1, 0, 32'h0);

      // watchdog: six retires with MAX=4
      do_reset();
      for (int i = 0; i < 6; i++) ret(I_ADDI, 1, i + 1);

      // halt completing on the same edge as the MAX-th retire
      do_reset();
      ret(I_ADD, 1, 32'd1);
      ret(I_ADD, 1, 32'd2);
      ret(H0, 1, 32'd12);
      ret(H1, 0, 32'h0);
      ret(I_ADD, 1, 32'd3);

      // randomised traffic
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 29) == 0) begin
            drive(0, $urandom_range(0, 1), $urandom, 1, $urandom, 0, $urandom);
         end else begin
            case ($urandom_range(0, 5))
               0: w = {$urandom} & 32'hFFFF_FF80 | 32'h63;
               1: w = {$urandom} & 32'hFFFF_FF80 | 32'h23;
               2: w = H0;
               3: w = H1;
               4: w = {$urandom} & 32'hFFFF_FF80 | 32'h13;
               default: w = $urandom;
            endcase
            drive(1, $urandom_range(0, 3) != 0, w, $urandom_range(0, 1), $urandom,
                  $urandom_range(0, 1), $urandom);
         end
      end

      @(posedge CLK);
      #2;
      check("scoreboard_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/riscv_retire_monitor.md
Name: riscv_retire_monitor

Overview:
- Commit-side observer inside RISCV_TOP, fed by the writeback stage's retire bundle.
- Produces the architectural-visibility outputs the top-level bench samples each posedge: NUM_INST, OUTPUT_PORT, HALT.
- Adds a watchdog TIMEOUT flag.
- Pure observer: never stalls or alters the datapath.

Parameters:
- HALT_INST0, 32'h00C00093, first word of the halt sequence (addi x1,x0,12)
- HALT_INST1, 32'h00008067, second word of the halt sequence (jalr x0,0(x1))
- MAX_INST, 32'hFFFF_FFFF, retire count at which TIMEOUT asserts

Ports:
- CLK  in  1  clock
- RSTn  in  1  reset
- RET_VALID  in  1  one instruction retires this cycle
- RET_INST  in  32  retiring instruction word
- RET_RD_WE  in  1  retiring instruction writes rd (rd != x0 already qualified)
- RET_RD_WD  in  32  rd write data
- RET_BR_TAKEN  in  1  retiring branch was taken
- RET_MEM_ADDR  in  32  effective address of retiring store
- NUM_INST  out  32  retired-instruction count
- OUTPUT_PORT  out  32  observable result of last relevant retire
- HALT  out  1  halt sequence retired; sticky
- TIMEOUT  out  1  NUM_INST reached MAX_INST; sticky

Behaviour:
- Reset RSTn, synchronous, active-low; clock CLK.
- Reset values: NUM_INST=0, OUTPUT_PORT=0, HALT=0, TIMEOUT=0, FSM=IDLE.
- All outputs are registered; the retire in cycle N is visible after posedge N+1.
- NUM_INST and OUTPUT_PORT update on the same edge, so the bench sees a matched pair.
- Counting: each RET_VALID=1 cycle increments NUM_INST by 1.
  - Saturates at 32'hFFFF_FFFF; no wrap.
  - Frozen once HALT=1.
- OUTPUT_PORT update, on RET_VALID only, priority by opcode RET_INST[6:0]:
  - 7'b1100011 (branch) -> {31'b0, RET_BR_TAKEN}
  - 7'b0100011 (store) -> RET_MEM_ADDR
  - else if RET_RD_WE -> RET_RD_WD
  - else hold the previous value
- OUTPUT_PORT holds when RET_VALID=0, and is frozen once HALT=1.
- Halt FSM, states IDLE, ARMED, HALTED, advancing only on RET_VALID cycles:
  - IDLE: RET_INST==HALT_INST0 -> ARMED; else stay IDLE.
  - ARMED: RET_INST==HALT_INST1 -> HALTED; RET_INST==HALT_INST0 -> stay ARMED; other -> IDLE.
  - ARMED with RET_VALID=0 (bubbles): stay ARMED. Bubbles never disarm.
  - HALTED: absorbing until reset; HALT=1 exactly while in HALTED.
- Both halt-sequence instructions are counted and update OUTPUT_PORT like any other retire.
  - The jalr's rd=x0, so OUTPUT_PORT keeps the addi result (12).
- TIMEOUT: set on the edge where the updated NUM_INST == MAX_INST; sticky until reset.
  - Counting continues after TIMEOUT unless HALT is set.
- Simultaneous events: a halt-completing retire and the MAX_INST count on the same edge set HALT and TIMEOUT together.
- Reset mid-operation: synchronous reset overrides any retire in the same cycle; all state returns to reset values.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants OP_BRANCH, OP_STORE
  - default halt words HALT_INST0_DEF, HALT_INST1_DEF
  - halt FSM state typedef (IDLE/ARMED/HALTED, 2-bit)
- One sub-module: riscv_halt_detector.
  - Contains the FSM.
  - Inputs: CLK, RSTn, RET_VALID, RET_INST.
  - Output: HALT.
- Counter, OUTPUT_PORT mux and watchdog stay in the top of this block.

Test Plan:
- Reset then three retires (addi rd_wd=5, slti rd_wd=0, slti rd_wd=1), one per cycle -> after each edge NUM_INST=1,2,3 with OUTPUT_PORT=5,0,1; all outputs 0 during reset.
- Retire beq with RET_BR_TAKEN=1, then sw with RET_MEM_ADDR=0x100, then an instruction with RET_RD_WE=0 -> OUTPUT_PORT=1, then 0x100, then still 0x100; NUM_INST advances by 3.
- Retire HALT_INST0 (rd_wd=12), two RET_VALID=0 bubbles, HALT_INST1 -> HALT=1 one edge after the jalr retire; NUM_INST counts both; OUTPUT_PORT=12; further retires leave NUM_INST/OUTPUT_PORT unchanged.
- Retire HALT_INST0, add, HALT_INST1 -> HALT stays 0.
- Retire HALT_INST0, HALT_INST0, HALT_INST1 -> HALT=1.
- MAX_INST=4, retire 6 instructions -> TIMEOUT=1 on the 4th-retire edge and stays 1; NUM_INST reaches 6.
- Assert RSTn=0 mid-stream with RET_VALID=1, after HALT=1 -> next edge all outputs 0, FSM IDLE; retire HALT_INST1 alone -> HALT stays 0.
